// File: rtl/image_uart_sender_if.sv
// Controller / frame-buffer bundle for image_uart_sender.
// master = sender side, slave = controller + frame buffer side.
interface image_uart_sender_if #(
  parameter int ADDR_W = 17,
  parameter int PIX_W  = 8
);
  logic              start;
  logic              busy;
  logic              done;
  logic              tx;
  logic              readEnable;
  logic [ADDR_W-1:0] readAddr;
  logic [PIX_W-1:0]  readData;

  modport master (
    input  start,
    input  readData,
    output busy,
    output done,
    output tx,
    output readEnable,
    output readAddr
  );

  modport slave (
    output start,
    output readData,
    input  busy,
    input  done,
    input  tx,
    input  readEnable,
    input  readAddr
  );
endinterface

// File: rtl/image_uart_sender.sv
// Streams a stored frame out as 8N1 UART, one byte per pixel.
// IMAGE_UART_SENDER_HEADER_EN: prefix each frame with sync bytes A5, 5A.
module image_uart_sender #(
  parameter int ADDR_W       = 17,
  parameter int PIX_W        = 8,
  parameter int NUM_PIXELS   = 76800,
  parameter int CLKS_PER_BIT = 434
) (
  input logic                 clock,
  input logic                 reset,
  image_uart_sender_if.master bus
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST =
    BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W-1:0] LAST_PIX =
    ADDR_W'(NUM_PIXELS - 1);
  localparam logic [3:0] STOP_BIT = 4'd9;

`ifdef IMAGE_UART_SENDER_HEADER_EN
  localparam logic [7:0] SYNC0 = 8'hA5;
  localparam logic [7:0] SYNC1 = 8'h5A;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef IMAGE_UART_SENDER_HEADER_EN
    S_HDR,
`endif
    S_RD,
    S_LAT,
    S_TX,
    S_FIN
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [3:0]        bit_q, bit_d;
  logic [7:0]        byte_q, byte_d;
`ifdef IMAGE_UART_SENDER_HEADER_EN
  logic              hdr_q, hdr_d;
`endif

  logic              bit_end;
  logic              frame_end;
  logic [BAUD_W-1:0] ser_baud;
  logic [3:0]        ser_bit;
  logic [2:0]        bit_idx;
  logic              ser_tx;
  logic              serializing;

  assign bit_end   = (baud_q == BAUD_LAST);
  assign frame_end = bit_end && (bit_q == STOP_BIT);

  assign ser_baud = bit_end ? '0 : baud_q + BAUD_W'(1);

  always_comb begin
    ser_bit = bit_q;
    if (frame_end) begin
      ser_bit = '0;
    end else if (bit_end) begin
      ser_bit = bit_q + 4'd1;
    end
  end

  // Data bit n sits at frame position n+1; 3-bit wrap maps 8 to 7.
  assign bit_idx = bit_q[2:0] - 3'd1;

  always_comb begin
    ser_tx = byte_q[bit_idx];
    unique case (1'b1)
      (bit_q == 4'd0):     ser_tx = 1'b0;
      (bit_q == STOP_BIT): ser_tx = 1'b1;
      default:             ser_tx = byte_q[bit_idx];
    endcase
  end

  always_comb begin
    serializing = (state_q == S_TX);
`ifdef IMAGE_UART_SENDER_HEADER_EN
    if (state_q == S_HDR) begin
      serializing = 1'b1;
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
`ifdef IMAGE_UART_SENDER_HEADER_EN
      hdr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
`ifdef IMAGE_UART_SENDER_HEADER_EN
      hdr_q   <= hdr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
`ifdef IMAGE_UART_SENDER_HEADER_EN
    hdr_d   = hdr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          cnt_d  = '0;
          baud_d = '0;
          bit_d  = '0;
`ifdef IMAGE_UART_SENDER_HEADER_EN
          byte_d  = SYNC0;
          hdr_d   = 1'b0;
          state_d = S_HDR;
`else
          state_d = S_RD;
`endif
        end
      end
`ifdef IMAGE_UART_SENDER_HEADER_EN
      S_HDR: begin
        baud_d = ser_baud;
        bit_d  = ser_bit;
        if (frame_end) begin
          if (hdr_q) begin
            state_d = S_RD;
          end else begin
            hdr_d  = 1'b1;
            byte_d = SYNC1;
          end
        end
      end
`endif
      S_RD: begin
        addr_d  = cnt_q;
        state_d = S_LAT;
      end
      S_LAT: begin
        byte_d  = bus.readData[PIX_W-1 -: 8];
        baud_d  = '0;
        bit_d   = '0;
        state_d = S_TX;
      end
      S_TX: begin
        baud_d = ser_baud;
        bit_d  = ser_bit;
        if (frame_end) begin
          if (cnt_q == LAST_PIX) begin
            state_d = S_FIN;
          end else begin
            cnt_d   = cnt_q + ADDR_W'(1);
            state_d = S_RD;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.busy       = (state_q != S_IDLE) &&
                          (state_q != S_FIN);
  assign bus.done       = (state_q == S_FIN);
  assign bus.readEnable = (state_q == S_RD);
  // Address shows the live counter only while reading.
  assign bus.readAddr   = (state_q == S_RD) ? cnt_q : addr_q;
  assign bus.tx         = serializing ? ser_tx : 1'b1;

endmodule

// File: tb/tb_image_uart_sender.sv
// Bench for image_uart_sender: 8-bit and 10-bit pixel instances
// driven in lockstep against a timing/byte-stream model.
module tb_image_uart_sender;

  localparam int AW  = 4;
  localparam int CPB = 4;
  localparam int NP  = 4;
  localparam int PER = 2 + 10 * CPB;
`ifdef IMAGE_UART_SENDER_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int HOFF  = HDR * 20 * CPB;
  localparam int TOTAL = HOFF + NP * PER;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem8  [NP];
  logic [9:0] mem10 [NP];

  always #5 clock = ~clock;

  image_uart_sender_if #(.ADDR_W(AW), .PIX_W(8))  bus8 ();
  image_uart_sender_if #(.ADDR_W(AW), .PIX_W(10)) bus10 ();

  assign bus8.start  = start;
  assign bus10.start = start;

  always @(posedge clock) begin
    if (bus8.readEnable) bus8.readData <= mem8[bus8.readAddr];
    if (bus10.readEnable) bus10.readData <= mem10[bus10.readAddr];
  end

  image_uart_sender #(
    .ADDR_W(AW), .PIX_W(8),
    .NUM_PIXELS(NP), .CLKS_PER_BIT(CPB)
  ) dut8 (
    .clock(clock), .reset(reset), .bus(bus8)
  );

  image_uart_sender #(
    .ADDR_W(AW), .PIX_W(10),
    .NUM_PIXELS(NP), .CLKS_PER_BIT(CPB)
  ) dut10 (
    .clock(clock), .reset(reset), .bus(bus10)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h",
             tag, obs, exp);
    end
  endtask

  // Expected line level s cycles after the accepting edge.
  function automatic logic exp_tx_at(input int s,
                                     input logic [7:0] b [NP]);
    logic [7:0] v;
    int pos, t, r, p;
    if (s < HOFF) begin
      v   = (s < 10 * CPB) ? 8'hA5 : 8'h5A;
      pos = (s % (10 * CPB)) / CPB;
    end else begin
      t = s - HOFF;
      p = t / PER;
      r = t % PER;
      if (p >= NP || r < 2) return 1'b1;
      v   = b[p];
      pos = (r - 2) / CPB;
    end
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return v[pos-1];
  endfunction

  // Decode the sampled line as a UART receiver would.
  task automatic check_stream(input string tag,
                              input logic w [$],
                              input logic [7:0] b [NP]);
    logic [7:0] ex [$];
    logic [7:0] got [$];
    logic [7:0] v;
    int i, ferr;
    if (HDR != 0) begin
      ex.push_back(8'hA5);
      ex.push_back(8'h5A);
    end
    for (int k = 0; k < NP; k++) ex.push_back(b[k]);
    i = 0;
    ferr = 0;
    v = '0;
    while (i + 10 * CPB <= w.size()) begin
      if (w[i] === 1'b0) begin
        for (int k = 0; k < 8; k++)
          v[k] = w[i + CPB/2 + CPB*(k+1)];
        if (w[i + CPB/2 + CPB*9] !== 1'b1) ferr++;
        got.push_back(v);
        i += 10 * CPB;
      end else begin
        i++;
      end
    end
    chk({tag, "_nbytes"}, got.size(), ex.size());
    chk({tag, "_framing"}, ferr, 0);
    for (int k = 0; k < ex.size(); k++)
      chk($sformatf("%s_byte%0d", tag, k),
          (k < got.size()) ? {24'd0, got[k]} : 32'hx,
          {24'd0, ex[k]});
  endtask

  task automatic run(input string tag,
                     input logic [7:0] m8 [NP],
                     input logic [9:0] m10 [NP],
                     input int rp,
                     input bit hold);
    logic [7:0] b10 [NP];
    logic w8 [$];
    logic w10 [$];
    int bad8, bad10, badre, baddone, badbusy;
    int t;
    logic ere;
    bad8 = 0; bad10 = 0; badre = 0;
    baddone = 0; badbusy = 0;
    for (int k = 0; k < NP; k++) begin
      mem8[k]  = m8[k];
      mem10[k] = m10[k];
      b10[k]   = m10[k][9:2];
    end
    @(negedge clock);
    start = 1'b1;
    for (int s = 0; s <= TOTAL + 1; s++) begin
      if (s > 0) begin
        @(negedge clock);
        start = hold || (s == rp);
      end
      @(posedge clock);
      #1;
      w8.push_back(bus8.tx);
      w10.push_back(bus10.tx);
      if (bus8.tx !== exp_tx_at(s, m8)) bad8++;
      if (bus10.tx !== exp_tx_at(s, b10)) bad10++;
      t = s - HOFF;
      ere = (s >= HOFF) && (t % PER == 0) && (t / PER < NP);
      if (bus8.readEnable !== ere) badre++;
      if (bus10.readEnable !== ere) badre++;
      if (ere && bus8.readAddr !== AW'(t / PER)) badre++;
      if (ere && bus10.readAddr !== AW'(t / PER)) badre++;
      if (bus8.done !== 1'(s == TOTAL)) baddone++;
      if (bus10.done !== 1'(s == TOTAL)) baddone++;
      if (bus8.busy !== 1'(s < TOTAL)) badbusy++;
    end
    if (!hold) start = 1'b0;
    chk({tag, "_tx8_wave"}, bad8, 0);
    chk({tag, "_tx10_wave"}, bad10, 0);
    chk({tag, "_reads"}, badre, 0);
    chk({tag, "_done"}, baddone, 0);
    chk({tag, "_busy"}, badbusy, 0);
    check_stream({tag, "_s8"}, w8, m8);
    check_stream({tag, "_s10"}, w10, b10);
  endtask

  initial begin
    logic [7:0] pat8 [NP];
    logic [9:0] pat10 [NP];
    logic [7:0] r8 [NP];
    logic [9:0] r10 [NP];
    int dn;

    repeat (2) @(posedge clock);
    #1;
    chk("rst_tx", bus8.tx, 1'b1);
    chk("rst_busy", bus8.busy, 1'b0);
    chk("rst_done", bus8.done, 1'b0);
    chk("rst_re", bus8.readEnable, 1'b0);
    chk("rst_addr", bus8.readAddr, 0);
    @(negedge clock);
    reset = 1'b0;

    pat8  = '{8'h55, 8'h00, 8'hFF, 8'h81};
    pat10 = '{10'h3FC, 10'h001, 10'h2AB, 10'h155};
    run("pat", pat8, pat10, -1, 1'b0);
    run("repulse", pat8, pat10, HOFF + PER + 10, 1'b0);

    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    @(negedge clock);
    start = 1'b0;
    repeat (HOFF + 2 * PER + 3) @(posedge clock);
    #1;
    chk("midrst_pre_tx", bus8.tx, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_tx", bus8.tx, 1'b1);
    chk("midrst_busy", bus8.busy, 1'b0);
    chk("midrst_done", bus8.done, 1'b0);
    dn = 0;
    repeat (3) begin
      @(posedge clock);
      #1;
      if (bus8.done !== 1'b0) dn++;
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (8) begin
      @(posedge clock);
      #1;
      if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) dn++;
    end
    chk("midrst_quiet", dn, 0);

    for (int k = 0; k < NP; k++) begin
      r8[k]  = 8'($urandom);
      r10[k] = 10'($urandom);
    end
    run("rand", r8, r10, -1, 1'b0);

    for (int k = 0; k < NP; k++) begin
      r8[k]  = 8'($urandom);
      r10[k] = 10'($urandom);
    end
    run("hold", r8, r10, -1, 1'b1);
    @(posedge clock);
    #1;
    chk("hold_restart_re", bus8.readEnable, 1'b1);
    chk("hold_restart_addr", bus8.readAddr, 0);
    chk("hold_restart_busy", bus8.busy, 1'b1);
    @(negedge clock);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
